// File: rtl/spi_bus_arbiter_pkg.sv
// Shared definitions for the SPI bus arbiter: FSM state encoding and the
// index-width helper used for owner / round-robin pointers.
package spi_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_LOAD      = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_NEXT      = 3'd5,
    ST_HOLD      = 3'd6
  } state_t;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at or
// above index rr, wrapping around. Reusable by any shared-bus arbiter.
module spi_rr_pick
  import spi_bus_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr,
  output logic            valid,
  output logic [IW-1:0]   grant
);

  // Scan from the highest offset down so the lowest offset from rr wins.
  always_comb begin : pick
    int idx;
    idx   = 0;
    valid = 1'b0;
    grant = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(rr) + i) % NREQ;
      if (req[idx]) begin
        valid = 1'b1;
        grant = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI master core between NREQ requesters,
// with per-requester active-low chip selects, programmable CS setup/hold and
// multi-word bursts that keep CS low until the requester flags its last word.
//
// Handshakes:
//   requester -> arbiter: req[i] is a valid qualifier for req_data/req_last
//     and must be held with stable data until ack[i]. ack[i] is a one-cycle
//     pulse in the cycle the word goes to the core; data/req may change on
//     the following cycle. done[i] pulses once per word, with rx_data valid
//     in that same cycle.
//   arbiter -> core: spi_transfer is a one-cycle start pulse with
//     spi_transmit_data valid alongside it; spi_ready high means the core is
//     idle/complete, low means a word is in flight.
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DL       = 8,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_last,
  input  logic [NREQ*DL-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  output logic [NREQ-1:0]    done,
  output logic [DL-1:0]      rx_data,
  output logic [NREQ-1:0]    cs_n,
  output logic               busy,
  output logic [DL-1:0]      spi_transmit_data,
  output logic               spi_transfer,
  input  logic               spi_ready,
  input  logic [DL-1:0]      spi_received_data,
  output logic [2:0]         dbg_state
);

  localparam int IW   = idx_width(NREQ);
  localparam int CMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CW   = $clog2(CMAX + 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic              last_q, last_d;
  logic [NREQ-1:0]   cs_n_q, cs_n_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [DL-1:0]     rx_q, rx_d;
  logic [DL-1:0]     tx_q, tx_d;
  logic              xfer_q, xfer_d;
  logic              busy_q, busy_d;
  logic              go_load;

  logic              pick_valid;
  logic [IW-1:0]     pick_idx;

  spi_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req),
    .rr    (rr_q),
    .valid (pick_valid),
    .grant (pick_idx)
  );

  // Next-state and registered-output computation. The word is captured on
  // the edge that enters LOAD so it sits on the core bus together with the
  // transfer pulse and the ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    last_d  = last_q;
    cs_n_d  = cs_n_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    ack_d   = '0;
    done_d  = '0;
    xfer_d  = 1'b0;
    go_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          cs_n_d  = ~(NREQ'(1) << pick_idx);
          cnt_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CW'(CS_SETUP - 1)) go_load = 1'b1;
        else                            cnt_d   = cnt_q + CW'(1);
      end
      ST_LOAD: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!spi_ready) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (spi_ready) begin
          rx_d            = spi_received_data;
          done_d[owner_q] = 1'b1;
          cnt_d           = '0;
          state_d         = last_q ? ST_HOLD : ST_NEXT;
        end
      end
      ST_NEXT: begin
        // Owner keeps the bus; a dropped req ends an unterminated burst.
        if (req[owner_q]) go_load = 1'b1;
        else begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == CW'(CS_HOLD - 1)) begin
          cs_n_d  = '1;
          cnt_d   = '0;
          rr_d    = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cs_n_d  = '1;
        state_d = ST_IDLE;
      end
    endcase

    if (go_load) begin
      state_d        = ST_LOAD;
      tx_d           = req_data[owner_q*DL +: DL];
      last_d         = req_last[owner_q];
      ack_d[owner_q] = 1'b1;
      xfer_d         = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset releases CS at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      last_q  <= 1'b0;
      cs_n_q  <= '1;
      ack_q   <= '0;
      done_q  <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      xfer_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      last_q  <= last_d;
      cs_n_q  <= cs_n_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      xfer_q  <= xfer_d;
      busy_q  <= busy_d;
    end
  end

  assign ack               = ack_q;
  assign done              = done_q;
  assign rx_data           = rx_q;
  assign cs_n              = cs_n_q;
  assign busy              = busy_q;
  assign spi_transmit_data = tx_q;
  assign spi_transfer      = xfer_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: a loopback SPI core model, a queued
// requester driver, an event monitor, and one task per scenario.
module tb_spi_bus_arbiter;
  import spi_bus_arbiter_pkg::*;

  localparam int NREQ     = 4;
  localparam int DL       = 8;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req      = '0;
  logic [NREQ-1:0]    req_last = '0;
  logic [NREQ*DL-1:0] req_data = '0;
  logic [NREQ-1:0]    ack, done, cs_n;
  logic [DL-1:0]      rx_data, spi_transmit_data;
  logic               busy, spi_transfer;
  logic               spi_ready = 1'b1;
  logic [DL-1:0]      spi_received_data = '0;
  logic [2:0]         dbg_state;

  int errors = 0;
  int checks = 0;

  spi_bus_arbiter #(
    .NREQ(NREQ), .DL(DL), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_last(req_last), .req_data(req_data),
    .ack(ack), .done(done), .rx_data(rx_data), .cs_n(cs_n), .busy(busy),
    .spi_transmit_data(spi_transmit_data), .spi_transfer(spi_transfer),
    .spi_ready(spi_ready), .spi_received_data(spi_received_data),
    .dbg_state(dbg_state)
  );

  // ---------------- loopback core model ----------------
  // Optional stall keeps ready high for stall_len cycles after the pulse,
  // then ready stays low for 4 cycles and returns with the echoed word.
  logic [DL-1:0] core_word = '0;
  logic          core_pending = 1'b0;
  int            core_delay = 0;
  int            core_bcnt = 0;
  int            stall_len = 0;

  always @(posedge clk) begin
    if (core_pending) begin
      if (core_delay == 0) begin
        spi_ready <= 1'b0; core_bcnt <= 3; core_pending <= 1'b0;
      end else core_delay <= core_delay - 1;
    end else if (!spi_ready) begin
      if (core_bcnt == 0) begin
        spi_ready <= 1'b1; spi_received_data <= core_word;
      end else core_bcnt <= core_bcnt - 1;
    end else if (spi_transfer) begin
      core_word <= spi_transmit_data;
      if (stall_len == 0) begin
        spi_ready <= 1'b0; core_bcnt <= 3;
      end else begin
        core_pending <= 1'b1; core_delay <= stall_len - 1;
      end
    end
  end

  // ---------------- requester driver ----------------
  typedef struct packed { logic last; logic [DL-1:0] data; } word_t;
  word_t wq [NREQ][$];

  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i] && wq[i].size() > 0) void'(wq[i].pop_front());
      if (rst && wq[i].size() > 0) begin
        req[i] = 1'b1;
        req_data[i*DL +: DL] = wq[i][0].data;
        req_last[i] = wq[i][0].last;
      end else begin
        req[i] = 1'b0;
        req_last[i] = 1'b0;
      end
    end
  end

  task automatic push_word(input int i, input logic last, input logic [DL-1:0] d);
    wq[i].push_back(word_t'{last: last, data: d});
  endtask

  task automatic sync;
    @(posedge clk); #1;
  endtask

  // ---------------- event monitor ----------------
  typedef struct { int cyc; int idx; logic [7:0] data; } ev_t;
  ev_t xfer_log[$], ack_log[$], done_log[$], cs_log[$];
  int  cyc = 0;
  int  setup_cnt = 0;
  logic [NREQ-1:0] cs_prev = '1;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      if (spi_transfer) xfer_log.push_back(ev_t'{cyc: cyc, idx: 0, data: spi_transmit_data});
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i])  ack_log.push_back(ev_t'{cyc: cyc, idx: i, data: 8'h00});
        if (done[i]) done_log.push_back(ev_t'{cyc: cyc, idx: i, data: rx_data});
      end
      if (cs_n !== cs_prev) cs_log.push_back(ev_t'{cyc: cyc, idx: 0, data: 8'(cs_n)});
      if (dbg_state == ST_SETUP) setup_cnt++;
    end
    cs_prev = cs_n;
  end

  task automatic clear_logs;
    xfer_log.delete(); ack_log.delete(); done_log.delete(); cs_log.delete();
    setup_cnt = 0;
  endtask

  task automatic wait_idle(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < max_cycles; n++) begin
      @(negedge clk); #1;
      if (!busy && req == '0 && spi_ready && !core_pending) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic reset_dut;
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (cs_n !== 4'hF) begin errors++; $display("FAIL reset_cs_n got=%h want=f", cs_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (ack !== 4'h0 || done !== 4'h0 || spi_transfer !== 1'b0) begin
      errors++; $display("FAIL reset_pulses ack=%h done=%h xfer=%b want 0", ack, done, spi_transfer); end
    checks++; if (rx_data !== 8'h00 || spi_transmit_data !== 8'h00) begin
      errors++; $display("FAIL reset_data rx=%h tx=%h want 00", rx_data, spi_transmit_data); end
    checks++; if (dbg_state !== 3'(ST_IDLE)) begin errors++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0 || cs_n !== 4'hF) begin
      errors++; $display("FAIL idle_no_req busy=%b cs_n=%h want 0/f", busy, cs_n); end
  endtask

  task automatic test_single_word;
    bit ok;
    clear_logs(); sync();
    push_word(0, 1'b1, 8'hAA);
    wait_idle(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_idle timeout"); end
    checks++; if (xfer_log.size() != 1 || ack_log.size() != 1 || done_log.size() != 1 || cs_log.size() != 2) begin
      errors++; $display("FAIL single_counts xfer=%0d ack=%0d done=%0d cs=%0d want 1/1/1/2",
        xfer_log.size(), ack_log.size(), done_log.size(), cs_log.size()); end
    if (xfer_log.size() >= 1 && ack_log.size() >= 1 && done_log.size() >= 1 && cs_log.size() >= 2) begin
      checks++; if (cs_log[0].data !== 8'h0E) begin errors++; $display("FAIL single_cs_low got=%h want=0e", cs_log[0].data); end
      checks++; if (xfer_log[0].cyc - cs_log[0].cyc != CS_SETUP) begin
        errors++; $display("FAIL single_setup got=%0d want=%0d", xfer_log[0].cyc - cs_log[0].cyc, CS_SETUP); end
      checks++; if (ack_log[0].cyc != xfer_log[0].cyc || ack_log[0].idx != 0) begin
        errors++; $display("FAIL single_ack cyc=%0d idx=%0d want cyc=%0d idx=0", ack_log[0].cyc, ack_log[0].idx, xfer_log[0].cyc); end
      checks++; if (xfer_log[0].data !== 8'hAA) begin errors++; $display("FAIL single_tx got=%h want=aa", xfer_log[0].data); end
      checks++; if (done_log[0].idx != 0 || done_log[0].data !== 8'hAA) begin
        errors++; $display("FAIL single_done idx=%0d rx=%h want 0/aa", done_log[0].idx, done_log[0].data); end
      checks++; if (cs_log[1].data !== 8'h0F || cs_log[1].cyc - done_log[0].cyc != CS_HOLD) begin
        errors++; $display("FAIL single_hold cs=%h dt=%0d want 0f/%0d", cs_log[1].data, cs_log[1].cyc - done_log[0].cyc, CS_HOLD); end
    end
  endtask

  task automatic test_contention;
    bit ok;
    reset_dut();
    clear_logs(); sync();
    push_word(0, 1'b1, 8'h11);
    push_word(2, 1'b1, 8'h22);
    wait_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cont_idle timeout"); end
    checks++; if (ack_log.size() != 2 || done_log.size() != 2 || cs_log.size() != 4) begin
      errors++; $display("FAIL cont_counts ack=%0d done=%0d cs=%0d want 2/2/4", ack_log.size(), done_log.size(), cs_log.size()); end
    if (ack_log.size() >= 2 && done_log.size() >= 2 && cs_log.size() >= 4) begin
      checks++; if (ack_log[0].idx != 0 || ack_log[1].idx != 2) begin
        errors++; $display("FAIL cont_order got=%0d,%0d want 0,2", ack_log[0].idx, ack_log[1].idx); end
      checks++; if (done_log[0].data !== 8'h11 || done_log[1].data !== 8'h22) begin
        errors++; $display("FAIL cont_rx got=%h,%h want 11,22", done_log[0].data, done_log[1].data); end
      checks++; if (cs_log[2].data !== 8'h0B || cs_log[2].cyc - cs_log[1].cyc != 1) begin
        errors++; $display("FAIL cont_gap cs=%h gap=%0d want 0b/1", cs_log[2].data, cs_log[2].cyc - cs_log[1].cyc); end
    end
    // Requester 0 alone moves the pointer to 1; then 0 and 1 contend.
    sync(); push_word(0, 1'b1, 8'h33);
    wait_idle(200, ok);
    clear_logs(); sync();
    push_word(0, 1'b1, 8'h44);
    push_word(1, 1'b1, 8'h55);
    wait_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cont2_idle timeout"); end
    checks++; if (ack_log.size() != 2 || done_log.size() != 2) begin
      errors++; $display("FAIL cont2_counts ack=%0d done=%0d want 2/2", ack_log.size(), done_log.size()); end
    if (ack_log.size() >= 2 && done_log.size() >= 2) begin
      checks++; if (ack_log[0].idx != 1 || ack_log[1].idx != 0) begin
        errors++; $display("FAIL cont2_order got=%0d,%0d want 1,0", ack_log[0].idx, ack_log[1].idx); end
      checks++; if (done_log[0].data !== 8'h55 || done_log[1].data !== 8'h44) begin
        errors++; $display("FAIL cont2_rx got=%h,%h want 55,44", done_log[0].data, done_log[1].data); end
    end
  endtask

  task automatic test_burst;
    bit ok;
    int bad;
    logic [7:0] exp_rx [3];
    exp_rx[0] = 8'h01; exp_rx[1] = 8'h02; exp_rx[2] = 8'h03;
    clear_logs(); sync();
    push_word(1, 1'b0, 8'h01);
    push_word(1, 1'b0, 8'h02);
    push_word(1, 1'b1, 8'h03);
    wait_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_idle timeout"); end
    checks++; if (ack_log.size() != 3 || done_log.size() != 3 || xfer_log.size() != 3) begin
      errors++; $display("FAIL burst_counts ack=%0d done=%0d xfer=%0d want 3/3/3", ack_log.size(), done_log.size(), xfer_log.size()); end
    checks++; if (cs_log.size() != 2) begin errors++; $display("FAIL burst_cs_changes got=%0d want=2", cs_log.size()); end
    else begin
      checks++; if (cs_log[0].data !== 8'h0D) begin errors++; $display("FAIL burst_cs_low got=%h want=0d", cs_log[0].data); end
    end
    checks++; if (setup_cnt != CS_SETUP) begin errors++; $display("FAIL burst_setup got=%0d want=%0d", setup_cnt, CS_SETUP); end
    if (ack_log.size() == 3 && done_log.size() == 3 && xfer_log.size() == 3) begin
      bad = 0;
      for (int k = 0; k < 3; k++) if (ack_log[k].idx != 1 || done_log[k].idx != 1 || done_log[k].data !== exp_rx[k]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL burst_words bad=%0d want=0", bad); end
      for (int k = 0; k < 2; k++) begin
        checks++; if (xfer_log[k+1].cyc - done_log[k].cyc != 1) begin
          errors++; $display("FAIL burst_next_gap k=%0d got=%0d want=1", k, xfer_log[k+1].cyc - done_log[k].cyc); end
      end
    end
  endtask

  task automatic test_abort;
    bit ok;
    clear_logs(); sync();
    push_word(3, 1'b0, 8'h5A);
    wait_idle(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_idle timeout"); end
    checks++; if (done_log.size() != 1 || ack_log.size() != 1 || cs_log.size() != 2) begin
      errors++; $display("FAIL abort_counts done=%0d ack=%0d cs=%0d want 1/1/2", done_log.size(), ack_log.size(), cs_log.size()); end
    if (done_log.size() >= 1 && cs_log.size() >= 2) begin
      checks++; if (done_log[0].idx != 3 || done_log[0].data !== 8'h5A) begin
        errors++; $display("FAIL abort_done idx=%0d rx=%h want 3/5a", done_log[0].idx, done_log[0].data); end
      checks++; if (cs_log[1].data !== 8'h0F || cs_log[1].cyc - done_log[0].cyc != 1 + CS_HOLD) begin
        errors++; $display("FAIL abort_release cs=%h dt=%0d want 0f/%0d", cs_log[1].data, cs_log[1].cyc - done_log[0].cyc, 1 + CS_HOLD); end
    end
    clear_logs(); sync();
    push_word(0, 1'b1, 8'h66);
    push_word(1, 1'b1, 8'h67);
    wait_idle(300, ok);
    checks++; if (ack_log.size() != 2) begin errors++; $display("FAIL abort_next_count got=%0d want=2", ack_log.size()); end
    else begin
      checks++; if (ack_log[0].idx != 0 || ack_log[1].idx != 1) begin
        errors++; $display("FAIL abort_next_order got=%0d,%0d want 0,1", ack_log[0].idx, ack_log[1].idx); end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit seen;
    int dn;
    clear_logs(); sync();
    push_word(2, 1'b1, 8'h77);
    seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk); #1;
      if (dbg_state == 3'(ST_WAIT_DONE)) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_reach WAIT_DONE not reached"); end
    rst = 1'b0;
    #1;
    checks++; if (cs_n !== 4'hF || busy !== 1'b0 || done !== 4'h0) begin
      errors++; $display("FAIL rstmid_now cs_n=%h busy=%b done=%h want f/0/0", cs_n, busy, done); end
    dn = 0;
    repeat (4) begin @(negedge clk); #1; if (done !== 4'h0) dn++; end
    checks++; if (dn != 0) begin errors++; $display("FAIL rstmid_no_done got=%0d want=0", dn); end
    rst = 1'b1;
    clear_logs(); sync();
    push_word(3, 1'b1, 8'h88);
    push_word(0, 1'b1, 8'h99);
    wait_idle(300, ok);
    checks++; if (ack_log.size() != 2 || done_log.size() != 2) begin
      errors++; $display("FAIL rstmid_counts ack=%0d done=%0d want 2/2", ack_log.size(), done_log.size()); end
    if (ack_log.size() >= 2) begin
      checks++; if (ack_log[0].idx != 0 || ack_log[1].idx != 3) begin
        errors++; $display("FAIL rstmid_order got=%0d,%0d want 0,3", ack_log[0].idx, ack_log[1].idx); end
    end
  endtask

  task automatic test_stall;
    bit ok;
    bit seen;
    int bad_state, bad_done, bad_xfer;
    stall_len = 10;
    clear_logs(); sync();
    push_word(2, 1'b1, 8'hC3);
    seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk); #1;
      if (spi_transfer) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL stall_xfer no transfer pulse"); end
    bad_state = 0; bad_done = 0; bad_xfer = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (dbg_state !== 3'(ST_WAIT_BUSY)) bad_state++;
      if (done !== 4'h0) bad_done++;
      if (spi_transfer !== 1'b0) bad_xfer++;
    end
    checks++; if (bad_state != 0) begin errors++; $display("FAIL stall_state cycles_out=%0d want=0", bad_state); end
    checks++; if (bad_done != 0) begin errors++; $display("FAIL stall_done got=%0d want=0", bad_done); end
    checks++; if (bad_xfer != 0) begin errors++; $display("FAIL stall_xfer2 got=%0d want=0", bad_xfer); end
    wait_idle(200, ok);
    stall_len = 0;
    checks++; if (!ok) begin errors++; $display("FAIL stall_idle timeout"); end
    checks++; if (done_log.size() != 1 || xfer_log.size() != 1) begin
      errors++; $display("FAIL stall_counts done=%0d xfer=%0d want 1/1", done_log.size(), xfer_log.size()); end
    else begin
      checks++; if (done_log[0].data !== 8'hC3) begin errors++; $display("FAIL stall_rx got=%h want=c3", done_log[0].data); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_word();
    test_contention();
    test_burst();
    test_abort();
    test_reset_mid();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
